clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//   Run-time programmable integer clock divider with glitch-free ratio switching.
//   Produces div_clk with period N clk cycles and 50% duty for both even and odd N.
//   Odd N uses a negedge-retimed copy of the output.
//   A req/ack config port lets a register block or power manager change N.
//   The new ratio takes effect only at a period boundary, so there is no runt or stretched pulse.
//   Sits between the clock source and the clock consumers; the only writer of the active ratio.
// PARAMETERS
//   DIV_W    4   width of ratio field; legal N = 2 .. 2**DIV_W-1
//   DEF_DIV  5   ratio loaded at reset (must be legal)
// PORTS
//   clk         in   1      source clock
//   rst_n       in   1      reset, asynchronous, active-low
//   cfg_req     in   1      ratio change request; held high until cfg_ack
//   cfg_div     in   DIV_W  requested ratio; stable while cfg_req high
//   cfg_ack     out  1      1-cycle pulse: request completed (applied or rejected)
//   cfg_err     out  1      valid with cfg_ack: 1 = rejected (cfg_div < 2), ratio unchanged
//   cur_div     out  DIV_W  currently active ratio
//   period_tick out  1      1-cycle pulse on the clk cycle where cnt == cur_div-1 (last cycle of a period)
//   div_clk     out  1      divided clock
//   en          in   1      present only with CLKDIV_GATE_EN; 1 = run
// BEHAVIOUR
//   Reset: cnt=0, cur_div=DEF_DIV, div_clk=0, cfg_ack=0, cfg_err=0, period_tick=0, state=RUN.
//     With CLKDIV_GATE_EN the reset state is STOP.
//   Counter: cnt counts 0..cur_div-1 on posedge clk and wraps to 0. Boundary = posedge where cnt == cur_div-1.
//   Waveform:
//     - clk_p (posedge reg) = 1 while next cnt < (N+1)/2.
//     - clk_n = clk_p sampled on negedge clk.
//     - div_clk = clk_p for even N; clk_p & clk_n for odd N.
//     - High time is N/2 clk periods (odd N: N/2 = x.5).
//     - First rising edge of div_clk is at the posedge where cnt goes 0.
//   FSM states: STOP, RUN, PEND, DRAIN. Encoding lives in the package.
//     RUN   : cfg_req high (and no cfg_ack last cycle) -> PEND.
//             If cfg_div < 2, go straight back to RUN with cfg_ack=1, cfg_err=1 next cycle.
//     PEND  : at boundary, cur_div <= cfg_div, cnt <= 0, cfg_ack=1 next cycle -> RUN.
//             Worst-case latency from request to ack is cur_div+1 cycles.
//     STOP  : cnt held 0, div_clk=0.
//             A legal request is applied on the next posedge, with ack the following cycle.
//   Handshake:
//     - cfg_req is ignored in the cycle cfg_ack is high.
//     - Requester drops cfg_req on seeing cfg_ack.
//     - Changing cfg_div while cfg_req is high is illegal (assertion).
//   Switching:
//     - The old period always completes in full; no div_clk edge occurs outside the old or new pattern.
//     - Requesting the same N still waits for the boundary and acks.
//   Simultaneous events: a boundary in the same cycle as request acceptance applies at that boundary (0-wait).
//   Reset mid-period: div_clk drops to 0 asynchronously; any pending request is discarded with no ack.
// CONFIGURATION
//   CLKDIV_GATE_EN defined:
//     - en port exists.
//     - en low in RUN -> DRAIN: the current period finishes, then STOP with div_clk=0.
//     - en high in STOP/DRAIN -> RUN; the period starts at the next posedge.
//     - A request pending in PEND takes priority over en going low; DRAIN is entered after the ack.
//   CLKDIV_GATE_EN undefined: no en port; STOP and DRAIN are unreachable; the block runs from reset.
// STRUCTURE
//   Package clk_div_pkg:
//     - state enum clk_div_state_e (STOP, RUN, PEND, DRAIN)
//     - localparam MIN_DIV = 2
//     - function half_hi(N) = (N+1)/2
//   Sub-module clk_div_core:
//     - cnt, clk_p, negedge clk_n and the output mux
//     - inputs: load, new_div, run
//     - output: boundary
//   clk_div_ctrl holds the FSM, the handshake and cur_div.
// TESTING
//   1. Reset, no requests, DEF_DIV=5 -> div_clk period 5 clk, high 2.5 clk; period_tick every 5th cycle; cur_div=5.
//   2. In RUN at cnt=1, request cfg_div=4 -> old 5-cycle period completes; cfg_ack 1 cycle after the boundary;
//      next periods are 4 clk with high 2; no extra edges.
//   3. Request cfg_div=1 -> cfg_ack=1, cfg_err=1 within 2 cycles; cur_div unchanged; waveform unchanged.
//   4. Sweep N = 2, 3, 7, 15 -> measured period N; high time N/2 (±0 by clk/negedge sampling).
//   5. Assert rst_n low at cnt=2 during PEND -> div_clk=0 immediately; cur_div=DEF_DIV; no ack after release.
//   6. CLKDIV_GATE_EN: drop en mid-period at N=6 -> period finishes, div_clk stays 0;
//      raise en -> first rising edge next posedge.

Source files
------------

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//   Shared definitions for the programmable clock divider.
//   - clk_div_state_e : controller state (STOP, RUN, PEND, DRAIN)
//   - MIN_DIV         : smallest legal division ratio
//   - HALF_W          : working width of half_hi(); ratio fields up to 16 bits
//   - half_hi(n)      : number of clk cycles the posedge-phase output is high
//                       in an n-cycle period, (n+1)/2
//   Optional feature macro used by the importing files: CLKDIV_GATE_EN.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } clk_div_state_e;

  localparam int MIN_DIV = 2;
  localparam int HALF_W  = 16;

  function automatic logic [HALF_W:0] half_hi(input logic [HALF_W-1:0] n);
    return ({1'b0, n} + {{HALF_W{1'b0}}, 1'b1}) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
//   Period counter and waveform generator for the clock divider.
//   The posedge register clk_p is high for the first (N+1)/2 cycles of a
//   period; clk_n is clk_p retimed on the falling edge.  Even ratios use clk_p
//   directly, odd ratios use clk_p & clk_n, which trims half a cycle off the
//   high phase and gives 50% duty.
//   Ports:
//     clk, rst_n  : source clock, asynchronous active-low reset
//     run         : 1 = count / generate in the coming cycle, 0 = hold idle
//     load        : a new ratio is applied at this edge (period restarts)
//     div         : ratio in force (cur_div of the controller)
//     new_div     : ratio being loaded, used when load is high
//     boundary    : high during the last cycle of a period
//     div_clk     : divided clock
//   DIV_W must not exceed clk_div_pkg::HALF_W.
// -----------------------------------------------------------------------------
module clk_div_core import clk_div_pkg::*; #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] new_div,
  output logic             boundary,
  output logic             div_clk
);

  localparam int CW = HALF_W + 1;

  logic [DIV_W-1:0] cnt_q, cnt_d, nxt_div;
  logic             running_q;
  logic             clk_p_q, clk_p_d;
  logic             clk_n_q;

  // running_q distinguishes "idle with cnt at 0" from "active at cnt 0", so
  // the first edge after reset or after a restart opens a fresh period.
  assign boundary = running_q && (cnt_q == div - DIV_W'(1));

  always_comb begin
    nxt_div = load ? new_div : div;
    cnt_d   = cnt_q + DIV_W'(1);
    if (!running_q || boundary || load) begin
      cnt_d = '0;
    end
    // clk_p follows the count it is about to hold, so it rises on the same
    // edge that starts a period.
    clk_p_d = (CW'(cnt_d) < half_hi(HALF_W'(nxt_div)));
    if (!run) begin
      cnt_d   = '0;
      clk_p_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
      clk_p_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      running_q <= run;
      clk_p_q   <= clk_p_d;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_p_q;
    end
  end

  // Ratio changes only at a period start, when both clk_p and clk_n are low,
  // so switching the mux there cannot produce a glitch.
  assign div_clk = div[0] ? (clk_p_q & clk_n_q) : clk_p_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//   Run-time programmable integer clock divider with glitch-free ratio
//   switching.  Holds the controller FSM, the config handshake and the active
//   ratio; the counter and waveform live in clk_div_core.
//   Parameters: DIV_W (ratio width, legal N = 2 .. 2**DIV_W-1, DIV_W <= 16),
//               DEF_DIV (ratio after reset).
//   Ports:
//     clk, rst_n   : source clock, asynchronous active-low reset
//     cfg_req      : ratio change request
//     cfg_div      : requested ratio
//     cfg_ack      : one-cycle completion pulse
//     cfg_err      : with cfg_ack, 1 = request rejected (ratio < 2)
//     cur_div      : active ratio
//     period_tick  : high in the last clk cycle of every period
//     div_clk      : divided clock
//     en           : run enable, only when CLKDIV_GATE_EN is defined
//   Macro CLKDIV_GATE_EN adds the en port and the STOP/DRAIN gating; without
//   it the divider runs from reset and STOP/DRAIN are never entered.
//
//   Handshake: the requester raises cfg_req with cfg_div and holds both
//   stable until it sees cfg_ack; it then drops cfg_req.  The controller
//   accepts cfg_req only in a cycle where cfg_ack is low, answers every
//   accepted request with exactly one cfg_ack pulse (cfg_err alongside) and
//   never acknowledges a request that was cut off by reset.
// -----------------------------------------------------------------------------
module clk_div_ctrl import clk_div_pkg::*; #(
  parameter int DIV_W   = 4,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             period_tick,
  output logic             div_clk
`ifdef CLKDIV_GATE_EN
  ,
  input  logic             en
`endif
);

  clk_div_state_e   state_q, state_d;
  logic [DIV_W-1:0] cur_div_q;
  logic             ack_q, err_q;
  logic             ack_d, err_d;
  logic             load, run, boundary;
  logic             accept, legal, en_i;

`ifdef CLKDIV_GATE_EN
  localparam clk_div_state_e RST_STATE = STOP;
  assign en_i = en;
`else
  localparam clk_div_state_e RST_STATE = RUN;
  assign en_i = 1'b1;
`endif

  assign accept = cfg_req && !ack_q;
  assign legal  = (cfg_div >= DIV_W'(MIN_DIV));

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      RUN: begin
        if (accept && !legal) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else if (accept && boundary) begin
          // Request lands on the last cycle of a period: apply right away.
          load  = 1'b1;
          ack_d = 1'b1;
        end else if (accept) begin
          state_d = PEND;
        end else if (!en_i) begin
          state_d = boundary ? STOP : DRAIN;
        end
      end
      PEND: begin
        // en is not looked at here: the pending request completes first.
        if (boundary) begin
          load    = 1'b1;
          ack_d   = 1'b1;
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (en_i) begin
          state_d = RUN;
        end else if (boundary) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (accept) begin
          ack_d = 1'b1;
          if (legal) begin
            load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (en_i) begin
          state_d = RUN;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // The core looks at the state being entered, so the edge that moves into
  // STOP already parks the counter instead of opening another period.
  assign run = (state_d != STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      cur_div_q <= DIV_W'(DEF_DIV);
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (load) begin
        cur_div_q <= cfg_div;
      end
    end
  end

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (load),
    .div      (cur_div_q),
    .new_div  (cfg_div),
    .boundary (boundary),
    .div_clk  (div_clk)
  );

  assign cfg_ack     = ack_q;
  assign cfg_err     = err_q;
  assign cur_div     = cur_div_q;
  assign period_tick = boundary;

  // cfg_div must not move while a request is outstanding.
  cfg_div_stable_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    (cfg_req && $past(cfg_req) && !$past(cfg_ack)) |-> (cfg_div == $past(cfg_div))
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//   Self-checking bench for clk_div_ctrl.  The reference model describes the
//   divider as periods on a cycle time line: a period of N cycles starts at
//   cycle m_ps, div_clk is high over half-cycle window [0,N) for even N and
//   [1,N+1) for odd N, period_tick marks the last cycle, and a ratio change
//   takes effect at the first period end at or after the request.
//   Define CLKDIV_GATE_EN to also exercise the en gating.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int DIV_W   = 4;
  localparam int DEF_DIV = 5;
  localparam int INF     = 1 << 30;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_req = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ack, cfg_err, period_tick, div_clk;
  logic [DIV_W-1:0] cur_div;
`ifdef CLKDIV_GATE_EN
  logic             en = 1'b0;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_req     (cfg_req),
    .cfg_div     (cfg_div),
    .cfg_ack     (cfg_ack),
    .cfg_err     (cfg_err),
    .cur_div     (cur_div),
    .period_tick (period_tick),
    .div_clk     (div_clk)
`ifdef CLKDIV_GATE_EN
    ,
    .en          (en)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc;                      // posedges since reset release
  int m_div, m_ps, m_end;       // active ratio, period-train start, last active cycle
  int sw_at, sw_div;            // pending ratio change: first cycle of new train
  int exp_ack_cyc;
  bit exp_err;
  logic [DIV_W-1:0] exp_q[$];   // expected cur_div at each ack

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit active(input int c);
    return (c >= m_ps) && (c <= m_end);
  endfunction

  function automatic int phase(input int c);
    return (c - m_ps) % m_div;
  endfunction

  // Expected div_clk level, in half cycles from the period start.
  function automatic bit exp_level(input int c, input bit neg);
    int t;
    if (!active(c)) return 1'b0;
    t = 2 * phase(c) + (neg ? 1 : 0);
    if (m_div % 2 == 0) return (t < m_div);
    return (t >= 1) && (t < m_div + 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step_pos();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == sw_at) begin
      m_div = sw_div;
      m_ps  = sw_at;
      sw_at = -1;
    end
    check("div_clk_pos", 32'(div_clk), 32'(exp_level(cyc, 1'b0)));
    check("period_tick", 32'(period_tick), 32'(active(cyc) && (phase(cyc) == m_div - 1)));
    check("cfg_ack", 32'(cfg_ack), 32'(cyc == exp_ack_cyc));
    check("cfg_err", 32'(cfg_err), 32'((cyc == exp_ack_cyc) && exp_err));
    check("cur_div", 32'(cur_div), 32'(m_div));
    if (cyc == exp_ack_cyc) begin
      if (exp_q.size() > 0) begin
        check("cur_div_at_ack", 32'(cur_div), 32'(exp_q.pop_front()));
      end
      cfg_req = 1'b0;
    end
  endtask

  task automatic step_neg();
    @(negedge clk);
    #1;
    check("div_clk_neg", 32'(div_clk), 32'(exp_level(cyc, 1'b1)));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step_neg();
      step_pos();
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 64; i++) begin
      step_neg();
      step_pos();
      if (active(cyc) && phase(cyc) == p) break;
    end
  endtask

  task automatic start_req(input int d);
    int t;
    cfg_req = 1'b1;
    cfg_div = DIV_W'(d);
    if (d < 2) begin
      exp_ack_cyc = cyc + 1;
      exp_err     = 1'b1;
      exp_q.push_back(DIV_W'(m_div));
    end else begin
      t = cyc;
      for (int i = 0; i < 64; i++) begin
        if (t >= m_ps && ((t - m_ps) % m_div) == m_div - 1) break;
        t++;
      end
      exp_ack_cyc = t + 1;
      exp_err     = 1'b0;
      sw_at       = t + 1;
      sw_div      = d;
      exp_q.push_back(DIV_W'(d));
    end
  endtask

  task automatic finish_req();
    for (int i = 0; i < 64 && cyc < exp_ack_cyc; i++) begin
      step_neg();
      step_pos();
    end
    step_neg();
    step_pos();
  endtask

  task automatic do_req(input int d);
    start_req(d);
    finish_req();
  endtask

  task automatic apply_reset();
    rst_n = 1'b1;
    #1;
    rst_n   = 1'b0;
    cfg_req = 1'b0;
`ifdef CLKDIV_GATE_EN
    en = 1'b0;
`endif
    #1;
    check("rst_div_clk", 32'(div_clk), 32'd0);
    check("rst_cur_div", 32'(cur_div), 32'(DEF_DIV));
    check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_div_clk", 32'(div_clk), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
`ifdef CLKDIV_GATE_EN
    en = 1'b1;
`endif
    cyc         = 0;
    m_div       = DEF_DIV;
    m_ps        = 1;
    m_end       = INF;
    sw_at       = -1;
    exp_ack_cyc = -1;
    exp_err     = 1'b0;
    exp_q.delete();
    step_pos();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sweep[4];
    int t;
    sweep = '{2, 3, 7, 15};

    apply_reset();
    run_cycles(3 * DEF_DIV + 2);

    // switch 5 -> 4 requested at cnt = 1, then a same-ratio request
    wait_phase(1);
    do_req(4);
    run_cycles(3 * 4);
    wait_phase(2);
    do_req(4);

    // rejected ratios leave everything untouched
    do_req(1);
    run_cycles(2);
    do_req(0);
    run_cycles(4);

    // request raised in the last cycle of a period applies at that boundary
    wait_phase(m_div - 1);
    do_req(6);
    run_cycles(2 * 6);

    foreach (sweep[i]) begin
      do_req(sweep[i]);
      run_cycles(3 * sweep[i]);
    end

    repeat (20) begin
      run_cycles(int'($urandom_range(0, 2 * m_div)));
      do_req(int'($urandom_range(0, 15)));
      run_cycles(int'($urandom_range(m_div, 2 * m_div)));
    end

    // reset while a request is pending, div_clk high at cnt = 2
    do_req(7);
    wait_phase(0);
    start_req(3);
    step_neg();
    step_pos();
    step_neg();
    step_pos();
    apply_reset();
    run_cycles(3 * DEF_DIV);

`ifdef CLKDIV_GATE_EN
    // drop en mid-period at N = 6, then restart
    do_req(6);
    wait_phase(2);
    en = 1'b0;
    t = cyc;
    for (int i = 0; i < 64; i++) begin
      if (((t - m_ps) % m_div) == m_div - 1) break;
      t++;
    end
    m_end = t;
    run_cycles(2 * 6 + 4);
    en    = 1'b1;
    m_ps  = cyc + 1;
    m_end = INF;
    run_cycles(3 * 6);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
